// File: rtl/if_stage_branch_predictor_if.sv
// Fetch-stage bus between the PC generator and the rest of the pipeline.
// Carries EX redirect/training inputs and the IF fetch/prediction outputs.
interface if_stage_branch_predictor_if #(
  parameter int WORD_SIZE = 16
);
  logic                 stall_IF;
  logic                 mispredict_EX;
  logic [WORD_SIZE-1:0] correct_pc_EX;
  logic                 update_valid_EX;
  logic [WORD_SIZE-1:0] update_pc_EX;
  logic                 update_taken_EX;
  logic [WORD_SIZE-1:0] update_target_EX;
  logic [WORD_SIZE-1:0] pc_IF;
  logic [WORD_SIZE-1:0] branch_predicted_pc_IF;
  logic                 tag_match_IF;

  modport master (
    output stall_IF, mispredict_EX, correct_pc_EX,
    output update_valid_EX, update_pc_EX,
    output update_taken_EX, update_target_EX,
    input  pc_IF, branch_predicted_pc_IF, tag_match_IF
  );

  modport slave (
    input  stall_IF, mispredict_EX, correct_pc_EX,
    input  update_valid_EX, update_pc_EX,
    input  update_taken_EX, update_target_EX,
    output pc_IF, branch_predicted_pc_IF, tag_match_IF
  );
endinterface

// File: rtl/if_stage_branch_predictor.sv
// Fetch PC generator with a direct-mapped BTB and 2-bit direction counters.
// EX resolutions train the tables; EX mispredicts redirect the PC.
module if_stage_branch_predictor #(
  parameter int WORD_SIZE = 16,
  parameter int IDX_BITS  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  if_stage_branch_predictor_if.slave   bus
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = WORD_SIZE - IDX_BITS;

  logic                 r_valid  [ENTRIES];
  logic [TAG_W-1:0]     r_tag    [ENTRIES];
  logic [WORD_SIZE-1:0] r_target [ENTRIES];
  logic [1:0]           r_cnt    [ENTRIES];
  logic [WORD_SIZE-1:0] r_pc;

  logic [IDX_BITS-1:0]  w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic                 w_hit;
  logic [WORD_SIZE-1:0] w_pc_inc;
  logic [WORD_SIZE-1:0] w_pred;

  logic [IDX_BITS-1:0]  w_uidx;
  logic [TAG_W-1:0]     w_utag;
  logic                 w_uhit;
  logic [1:0]           w_cnt_nxt;

  assign w_idx    = r_pc[IDX_BITS-1:0];
  assign w_tag    = r_pc[WORD_SIZE-1:IDX_BITS];
  assign w_hit    = !reset && r_valid[w_idx]
                    && (r_tag[w_idx] == w_tag);
  assign w_pc_inc = r_pc + WORD_SIZE'(1);
  assign w_pred   = (w_hit && r_cnt[w_idx][1])
                    ? r_target[w_idx] : w_pc_inc;

  assign bus.pc_IF                  = r_pc;
  assign bus.tag_match_IF           = w_hit;
  assign bus.branch_predicted_pc_IF = w_pred;

  assign w_uidx = bus.update_pc_EX[IDX_BITS-1:0];
  assign w_utag = bus.update_pc_EX[WORD_SIZE-1:IDX_BITS];
  assign w_uhit = r_valid[w_uidx]
                  && (r_tag[w_uidx] == w_utag);

  // Saturating step of the counter at the update index
  always_comb begin
    w_cnt_nxt = r_cnt[w_uidx];
    if (bus.update_taken_EX) begin
      if (r_cnt[w_uidx] != 2'b11)
        w_cnt_nxt = r_cnt[w_uidx] + 2'b01;
    end else begin
      if (r_cnt[w_uidx] != 2'b00)
        w_cnt_nxt = r_cnt[w_uidx] - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= '0;
    end else if (bus.mispredict_EX) begin
      r_pc <= bus.correct_pc_EX;
    end else if (!bus.stall_IF) begin
      r_pc <= w_pred;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_cnt[i]   <= 2'b01;
      end
    end else if (bus.update_valid_EX) begin
      if (w_uhit) begin
        r_cnt[w_uidx] <= w_cnt_nxt;
      end else if (bus.update_taken_EX) begin
        r_valid[w_uidx] <= 1'b1;
        r_cnt[w_uidx]   <= 2'b10;
      end
    end
  end

  // Any taken update leaves tag equal (hit) or allocates (miss)
  always_ff @(posedge clk) begin
    if (!reset && bus.update_valid_EX
        && bus.update_taken_EX) begin
      r_tag[w_uidx]    <= w_utag;
      r_target[w_uidx] <= bus.update_target_EX;
    end
  end
endmodule

// File: tb/tb_if_stage_branch_predictor.sv
// Table-driven bench for the fetch-stage branch predictor.
// Each row drives one cycle and states that cycle's expected outputs.
module tb_if_stage_branch_predictor;
  logic clk;
  logic reset;

  if_stage_branch_predictor_if #(.WORD_SIZE(16)) bus ();

  if_stage_branch_predictor #(
    .WORD_SIZE(16),
    .IDX_BITS (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        st;
    logic        mis;
    logic [15:0] cpc;
    logic        uv;
    logic [15:0] upc;
    logic        ut;
    logic [15:0] utg;
    logic [15:0] epc;
    logic [15:0] epred;
    logic        etm;
  } vec_t;

  typedef struct {
    int          row;
    logic [15:0] epc;
    logic [15:0] epred;
    logic        etm;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   drv_done = 1'b0;

  function automatic vec_t v(
    input logic rst, input logic st, input logic mis,
    input logic [15:0] cpc, input logic uv,
    input logic [15:0] upc, input logic ut,
    input logic [15:0] utg, input logic [15:0] epc,
    input logic [15:0] epred, input logic etm);
    vec_t r;
    r.rst = rst; r.st = st; r.mis = mis; r.cpc = cpc;
    r.uv = uv; r.upc = upc; r.ut = ut; r.utg = utg;
    r.epc = epc; r.epred = epred; r.etm = etm;
    return r;
  endfunction

  task automatic drive(input vec_t r);
    reset                = r.rst;
    bus.stall_IF         = r.st;
    bus.mispredict_EX    = r.mis;
    bus.correct_pc_EX    = r.cpc;
    bus.update_valid_EX  = r.uv;
    bus.update_pc_EX     = r.upc;
    bus.update_taken_EX  = r.ut;
    bus.update_target_EX = r.utg;
  endtask

  // Scoreboard: compare the cycle's outputs at the falling edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if (bus.pc_IF !== e.epc) begin
        bad++;
        $display("FAIL row%0d pc_IF got=%h want=%h",
                 e.row, bus.pc_IF, e.epc);
      end
      total++;
      if (bus.branch_predicted_pc_IF !== e.epred) begin
        bad++;
        $display("FAIL row%0d pred got=%h want=%h",
                 e.row, bus.branch_predicted_pc_IF, e.epred);
      end
      total++;
      if (bus.tag_match_IF !== e.etm) begin
        bad++;
        $display("FAIL row%0d tag_match got=%b want=%b",
                 e.row, bus.tag_match_IF, e.etm);
      end
    end
  end

  initial begin
    // rst st mis cpc uv upc ut utg | pc pred tm
    tbl.push_back(v(1,0,0,16'h0000,0,16'h0000,0,16'h0000, 16'h0000,16'h0001,0));
    tbl.push_back(v(0,0,0,16'h0000,0,16'h0000,0,16'h0000, 16'h0000,16'h0001,0));
    tbl.push_back(v(0,0,0,16'h0000,0,16'h0000,0,16'h0000, 16'h0001,16'h0002,0));
    tbl.push_back(v(0,0,0,16'h0000,0,16'h0000,0,16'h0000, 16'h0002,16'h0003,0));
    tbl.push_back(v(0,0,1,16'hFFFF,0,16'h0000,0,16'h0000, 16'h0003,16'h0004,0));
    tbl.push_back(v(0,0,0,16'h0000,0,16'h0000,0,16'h0000, 16'hFFFF,16'h0000,0));
    tbl.push_back(v(0,0,0,16'h0000,1,16'h0010,1,16'h0040, 16'h0000,16'h0001,0));
    tbl.push_back(v(0,0,1,16'h0010,0,16'h0000,0,16'h0000, 16'h0001,16'h0002,0));
    tbl.push_back(v(0,0,0,16'h0000,0,16'h0000,0,16'h0000, 16'h0010,16'h0040,1));
    tbl.push_back(v(0,0,0,16'h0000,1,16'h0010,0,16'h0000, 16'h0040,16'h0041,0));
    tbl.push_back(v(0,0,0,16'h0000,1,16'h0010,0,16'h0000, 16'h0041,16'h0042,0));
    tbl.push_back(v(0,0,1,16'h0010,0,16'h0000,0,16'h0000, 16'h0042,16'h0043,0));
    tbl.push_back(v(0,0,0,16'h0000,0,16'h0000,0,16'h0000, 16'h0010,16'h0011,1));
    tbl.push_back(v(0,0,0,16'h0000,1,16'h0010,1,16'h0040, 16'h0011,16'h0012,0));
    tbl.push_back(v(0,0,0,16'h0000,1,16'h0010,1,16'h0040, 16'h0012,16'h0013,0));
    tbl.push_back(v(0,0,0,16'h0000,1,16'h0010,1,16'h0040, 16'h0013,16'h0014,0));
    tbl.push_back(v(0,0,0,16'h0000,1,16'h0010,1,16'h0040, 16'h0014,16'h0015,0));
    tbl.push_back(v(0,0,1,16'h0010,1,16'h0010,0,16'h0000, 16'h0015,16'h0016,0));
    tbl.push_back(v(0,0,0,16'h0000,0,16'h0000,0,16'h0000, 16'h0010,16'h0040,1));
    tbl.push_back(v(0,0,1,16'h0110,0,16'h0000,0,16'h0000, 16'h0040,16'h0041,0));
    tbl.push_back(v(0,0,0,16'h0000,1,16'h0110,1,16'h0200, 16'h0110,16'h0111,0));
    tbl.push_back(v(0,0,1,16'h0010,0,16'h0000,0,16'h0000, 16'h0111,16'h0112,0));
    tbl.push_back(v(0,0,1,16'h0110,0,16'h0000,0,16'h0000, 16'h0010,16'h0011,0));
    tbl.push_back(v(0,0,0,16'h0000,0,16'h0000,0,16'h0000, 16'h0110,16'h0200,1));
    tbl.push_back(v(0,1,0,16'h0000,0,16'h0000,0,16'h0000, 16'h0200,16'h0201,0));
    tbl.push_back(v(0,1,0,16'h0000,0,16'h0000,0,16'h0000, 16'h0200,16'h0201,0));
    tbl.push_back(v(0,1,0,16'h0000,0,16'h0000,0,16'h0000, 16'h0200,16'h0201,0));
    tbl.push_back(v(0,1,1,16'h0080,0,16'h0000,0,16'h0000, 16'h0200,16'h0201,0));
    tbl.push_back(v(0,0,0,16'h0000,1,16'h0080,1,16'h0300, 16'h0080,16'h0081,0));
    tbl.push_back(v(0,0,1,16'h0080,0,16'h0000,0,16'h0000, 16'h0081,16'h0082,0));
    tbl.push_back(v(0,0,0,16'h0000,0,16'h0000,0,16'h0000, 16'h0080,16'h0300,1));
    tbl.push_back(v(1,0,0,16'h0000,1,16'h0500,1,16'h0600, 16'h0300,16'h0301,0));
    tbl.push_back(v(0,0,1,16'h0110,0,16'h0000,0,16'h0000, 16'h0000,16'h0001,0));
    tbl.push_back(v(0,0,1,16'h0500,0,16'h0000,0,16'h0000, 16'h0110,16'h0111,0));
    tbl.push_back(v(0,0,1,16'h0080,0,16'h0000,0,16'h0000, 16'h0500,16'h0501,0));
    tbl.push_back(v(0,0,1,16'h0700,1,16'h0700,0,16'h0000, 16'h0080,16'h0081,0));
    tbl.push_back(v(0,0,0,16'h0000,0,16'h0000,0,16'h0000, 16'h0700,16'h0701,0));

    drive(v(1,0,0,0,0,0,0,0,0,0,0));
    for (int i = 0; i < tbl.size(); i++) begin
      exp_t e;
      @(posedge clk);
      #1;
      drive(tbl[i]);
      e.row = i; e.epc = tbl[i].epc;
      e.epred = tbl[i].epred; e.etm = tbl[i].etm;
      sb.push_back(e);
    end
    drv_done = 1'b1;
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!(drv_done && sb.size() == 0) && cyc < 500) begin
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 500) begin
      total++;
      bad++;
      $display("FAIL timeout got=%0d want<%0d", cyc, 500);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
